// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, state encoding and ON/OFF constants for the ALU sequencer
package alu_pkg;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] PAR  = 2'b10;
    localparam logic [1:0] COMP = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences the ALU datapath load/start/done protocol for one client
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_opcode,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_overflow,
    output logic                  resp_timeout,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] alu_data,
    output logic [1:0]            opcode_value,
    output logic                  store_a,
    output logic                  store_b,
    output logic                  start,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [1:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   alu_data_q, alu_data_d;
    logic [1:0]              opcode_value_q, opcode_value_d;
    logic                    store_a_q, store_a_d;
    logic                    store_b_q, store_b_d;
    logic                    start_q, start_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_result_q, resp_result_d;
    logic                    resp_overflow_q, resp_overflow_d;
    logic                    resp_timeout_q, resp_timeout_d;
    logic                    has_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            op_q            <= '0;
            b_q             <= '0;
            alu_data_q      <= '0;
            opcode_value_q  <= '0;
            store_a_q       <= OFF;
            store_b_q       <= OFF;
            start_q         <= OFF;
            resp_valid_q    <= OFF;
            resp_result_q   <= '0;
            resp_overflow_q <= OFF;
            resp_timeout_q  <= OFF;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            op_q            <= op_d;
            b_q             <= b_d;
            alu_data_q      <= alu_data_d;
            opcode_value_q  <= opcode_value_d;
            store_a_q       <= store_a_d;
            store_b_q       <= store_b_d;
            start_q         <= start_d;
            resp_valid_q    <= resp_valid_d;
            resp_result_q   <= resp_result_d;
            resp_overflow_q <= resp_overflow_d;
            resp_timeout_q  <= resp_timeout_d;
        end
    end

    // Only arithmetic ops produce a meaningful carry/borrow.
    assign has_ovf = (op_q == ADD) || (op_q == SUB);

    // Outputs are registered, so each branch programs the values for the state being entered.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        op_d            = op_q;
        b_d             = b_q;
        alu_data_d      = '0;
        opcode_value_d  = opcode_value_q;
        store_a_d       = OFF;
        store_b_d       = OFF;
        start_d         = OFF;
        resp_valid_d    = resp_valid_q;
        resp_result_d   = resp_result_q;
        resp_overflow_d = resp_overflow_q;
        resp_timeout_d  = resp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_opcode;
                    b_d        = req_b;
                    alu_data_d = req_a;
                    store_a_d  = ON;
                    state_d    = LOAD_A;
                end
            end
            LOAD_A: begin
                alu_data_d = b_q;
                store_b_d  = ON;
                state_d    = LOAD_B;
            end
            LOAD_B: begin
                start_d        = ON;
                opcode_value_d = op_q;
                cnt_d          = '0;
                state_d        = EXEC;
            end
            EXEC: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (alu_done) begin
                    resp_valid_d    = ON;
                    resp_result_d   = result;
                    resp_overflow_d = has_ovf ? overflow : OFF;
                    resp_timeout_d  = OFF;
                    state_d         = RESP;
                end else if (cnt_q == LAST_CNT) begin
                    resp_valid_d    = ON;
                    resp_result_d   = '0;
                    resp_overflow_d = OFF;
                    resp_timeout_d  = ON;
                    state_d         = RESP;
                end else begin
                    start_d = ON;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d    = OFF;
                    resp_result_d   = '0;
                    resp_overflow_d = OFF;
                    resp_timeout_d  = OFF;
                    opcode_value_d  = '0;
                    cnt_d           = '0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign alu_data      = alu_data_q;
    assign opcode_value  = opcode_value_q;
    assign store_a       = store_a_q;
    assign store_b       = store_b_q;
    assign start         = start_q;
    assign resp_valid    = resp_valid_q;
    assign resp_result   = resp_result_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_timeout  = resp_timeout_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural datapath model
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_opcode = 2'b00;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] resp_result;
    logic       resp_overflow;
    logic       resp_timeout;
    logic       busy;
    logic [7:0] alu_data;
    logic [1:0] opcode_value;
    logic       store_a, store_b, start;
    logic       alu_done;
    logic [7:0] result;
    logic       overflow;

    alu_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_overflow(resp_overflow), .resp_timeout(resp_timeout), .busy(busy),
        .alu_data(alu_data), .opcode_value(opcode_value),
        .store_a(store_a), .store_b(store_b), .start(start),
        .alu_done(alu_done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Datapath model: latches operands, raises done 'model_delay' cycles after start (0 = never).
    logic [7:0] a_m = 8'h00, b_m = 8'h00;
    logic [8:0] m_sum;
    int         model_delay = 0;
    int         mcnt = 0;
    logic       model_done = 1'b0;
    logic       spur_done = 1'b0;

    always @(posedge clk) begin
        if (store_a) a_m <= alu_data;
        if (store_b) b_m <= alu_data;
        if (start) begin
            mcnt       <= mcnt + 1;
            model_done <= (model_delay != 0) && (mcnt + 1 == model_delay);
        end else begin
            mcnt       <= 0;
            model_done <= 1'b0;
        end
    end

    assign alu_done = model_done | spur_done;

    always_comb begin
        m_sum    = {1'b0, a_m} + {1'b0, b_m};
        result   = 8'h00;
        overflow = 1'b0;
        case (opcode_value)
            ADD:  begin result = m_sum[7:0];          overflow = m_sum[8];   end
            SUB:  begin result = a_m - b_m;           overflow = (a_m < b_m); end
            PAR:  begin result = {7'b0, ^(a_m ^ b_m)}; overflow = 1'b1;      end
            default: begin result = ~a_m;             overflow = 1'b1;       end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] r;
        logic       ovf;
        logic       tmo;
    } exp_t;
    exp_t sb[$];

    // Monitor: timestamps relative to accept, invariants, scoreboard pop on handshake.
    int   cyc = 0;
    int   acc_cyc = 0, hs_cyc = 0;
    int   t_sa = -1, t_sb = -1, t_st = -1, t_rv = -1;
    int   start_cnt = 0;
    int   viol = 0;
    logic in_exec = 1'b0;
    logic [1:0] op_seen = 2'b00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_exec = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                t_sa = -1; t_sb = -1; t_st = -1; t_rv = -1;
                start_cnt = 0;
            end
            if (store_a && t_sa < 0) t_sa = cyc - acc_cyc;
            if (store_b && t_sb < 0) t_sb = cyc - acc_cyc;
            if (start && t_st < 0) begin
                t_st = cyc - acc_cyc;
                in_exec = 1'b1;
                op_seen = opcode_value;
            end
            if (start) start_cnt++;
            if (resp_valid && t_rv < 0) t_rv = cyc - acc_cyc;
            if (32'(store_a) + 32'(store_b) + 32'(start) > 1) viol++;
            if (alu_data != 8'h00 && !store_a && !store_b) viol++;
            if (in_exec && opcode_value != op_seen) viol++;
            if (resp_valid && resp_ready) begin
                hs_cyc  = cyc;
                in_exec = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'(1'b0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_result", 32'(resp_result), 32'(e.r));
                    chk("resp_overflow", 32'(resp_overflow), 32'(e.ovf));
                    chk("resp_timeout", 32'(resp_timeout), 32'(e.tmo));
                end
            end
        end
    end

    task automatic send_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_accept", 32'(ok), 32'(1));
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (resp_valid) begin ok = 1; break; end
        end
        chk("resp_valid_seen", 32'(ok), 32'(1));
    endtask

    task automatic handshake();
        @(posedge clk); #1; resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, b;
        int         delay;
        logic [7:0] r;
        logic       ovf, tmo;
    } vec_t;
    vec_t vecs[8];

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        model_delay = v.delay;
        sb.push_back('{v.r, v.ovf, v.tmo});
        send_req(v.op, v.a, v.b);
        wait_valid();
        handshake();
        chk($sformatf("v%0d_t_store_a", i), 32'(t_sa), 32'(1));
        chk($sformatf("v%0d_t_store_b", i), 32'(t_sb), 32'(2));
        chk($sformatf("v%0d_t_start", i), 32'(t_st), 32'(3));
        chk($sformatf("v%0d_t_resp", i), 32'(t_rv), v.tmo ? 32'(19) : 32'(4 + v.delay));
        chk($sformatf("v%0d_start_cycles", i), 32'(start_cnt), v.tmo ? 32'(16) : 32'(v.delay + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] snap;
        logic        quiet;
        bit          ok;

        vecs[0] = '{ADD,  8'h7F, 8'h01, 2,  8'h80, 1'b0, 1'b0};
        vecs[1] = '{SUB,  8'h05, 8'h09, 3,  8'hFC, 1'b1, 1'b0};
        vecs[2] = '{PAR,  8'h0F, 8'h01, 1,  8'h01, 1'b0, 1'b0};
        vecs[3] = '{COMP, 8'h5A, 8'h00, 4,  8'hA5, 1'b0, 1'b0};
        vecs[4] = '{ADD,  8'hFF, 8'h02, 2,  8'h01, 1'b1, 1'b0};
        vecs[5] = '{ADD,  8'h10, 8'h20, 0,  8'h00, 1'b0, 1'b1};
        vecs[6] = '{SUB,  8'h30, 8'h10, 15, 8'h20, 1'b0, 1'b0};
        vecs[7] = '{SUB,  8'h01, 8'h02, 16, 8'h00, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({resp_valid, resp_result, resp_overflow, resp_timeout, busy,
                                  alu_data, opcode_value, store_a, store_b, start}), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", 32'(req_ready), 32'(1));
        chk("post_reset_busy", 32'(busy), 32'(0));

        for (int i = 0; i < 8; i++) run_vec(i);

        // Backpressure: response held 5 cycles while a new request waits.
        model_delay = 2;
        sb.push_back('{8'h80, 1'b0, 1'b0});
        sb.push_back('{8'hFC, 1'b1, 1'b0});
        send_req(ADD, 8'h7F, 8'h01);
        wait_valid();
        snap = {resp_valid, resp_result, resp_overflow, resp_timeout, busy, alu_data,
                opcode_value, store_a, store_b, start};
        @(posedge clk); #1;
        model_delay = 3;
        req_valid = 1'b1; req_opcode = SUB; req_a = 8'h05; req_b = 8'h09;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_stable", 32'({resp_valid, resp_result, resp_overflow, resp_timeout, busy,
                                  alu_data, opcode_value, store_a, store_b, start}), 32'(snap));
            chk("bp_req_ready", 32'(req_ready), 32'(0));
        end
        handshake();
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_accept_seen", 32'(ok), 32'(1));
        chk("bp_accept_after_hs", 32'(acc_cyc - hs_cyc), 32'(1));
        wait_valid();
        handshake();
        chk("bp_second_t_resp", 32'(t_rv), 32'(7));

        // Asynchronous reset in the middle of EXEC: no response may follow.
        model_delay = 0;
        send_req(ADD, 8'h01, 8'h02);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_start", 32'(start), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({resp_valid, resp_result, resp_overflow, resp_timeout, busy,
                                        alu_data, opcode_value, store_a, store_b, start}), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (resp_valid || busy) quiet = 1'b0;
        end
        chk("reset_no_response", 32'(quiet), 32'(1));
        run_vec(1);

        // Spurious done while IDLE and LOAD_A must not disturb the operation.
        model_delay = 3;
        sb.push_back('{8'h33, 1'b0, 1'b0});
        @(posedge clk); #1;
        spur_done = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_opcode = ADD; req_a = 8'h11; req_b = 8'h22;
        @(negedge clk);
        chk("spur_req_ready", 32'(req_ready), 32'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        spur_done = 1'b0;
        wait_valid();
        handshake();
        chk("spur_t_resp", 32'(t_rv), 32'(7));
        chk("spur_start_cycles", 32'(start_cnt), 32'(4));

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        chk("invariants", 32'(viol), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that sequences the 8-bit ALU datapath (store_a / store_b / start / alu_done protocol) on behalf of one client.
- Client hands over a complete operation (opcode, A, B) on a valid/ready request channel.
- Block loads A, then B, starts the datapath, waits for alu_done under a timeout, and returns result, overflow and timeout status on a valid/ready response channel.
- Sits between the system bus interface and the ALU datapath; only this block drives the datapath's control inputs.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the datapath.
TIMEOUT_CYCLES, 16, max cycles in EXEC before abort; legal range 2..255.
CNT_WIDTH, 8, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  client request valid
req_ready  output  1  block can accept request
req_opcode  input  2  00 ADD, 01 SUB, 10 PAR, 11 COMP
req_a  input  DATA_WIDTH  operand A
req_b  input  DATA_WIDTH  operand B
resp_valid  output  1  response valid
resp_ready  input  1  client accepts response
resp_result  output  DATA_WIDTH  captured result
resp_overflow  output  1  captured overflow/borrow (ADD/SUB only)
resp_timeout  output  1  operation aborted by timeout
busy  output  1  high in any state other than IDLE
alu_data  output  DATA_WIDTH  operand bus to datapath
opcode_value  output  2  opcode to datapath
store_a  output  1  latch alu_data into datapath A
store_b  output  1  latch alu_data into datapath B
start  output  1  datapath start
alu_done  input  1  datapath completion
result  input  DATA_WIDTH  datapath result
overflow  input  1  datapath overflow/borrow

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset (reset_n=0, asynchronous):
  - state=IDLE; timeout counter=0.
  - All outputs 0, except req_ready=1 once reset is released.
  - Reset mid-operation discards the latched request; no response is produced.
- Registered outputs: all datapath-side and response outputs. req_ready = (state==IDLE) and is combinational from state only.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, latch opcode/A/B and go to LOAD_A.
  - LOAD_A (1 cycle): store_a=1, alu_data=A. Go to LOAD_B.
  - LOAD_B (1 cycle): store_a=0, store_b=1, alu_data=B. Go to EXEC.
  - EXEC: store_b=0, start=1, opcode_value=latched opcode. Counter increments each cycle.
    - If alu_done=1 is sampled: capture result into resp_result and overflow into resp_overflow (forced 0 for PAR/COMP); resp_timeout=0; start=0 next cycle; go to RESP.
    - Else, if counter==TIMEOUT_CYCLES-1: resp_result=0, resp_overflow=0, resp_timeout=1, start=0; go to RESP.
    - alu_done and timeout in the same cycle: alu_done wins.
  - RESP: resp_valid=1; response fields held stable. On resp_ready=1: resp_valid=0, clear response fields and counter, go to IDLE.
- Datapath-side signal rules:
  - store_a, store_b and start are mutually exclusive in every cycle.
  - opcode_value is held stable from EXEC entry until RESP exit, because the datapath uses it when done is asserted.
  - alu_data returns to 0 outside LOAD_A/LOAD_B.
- Latency: request accept at cycle 0; store_a at cycle 1; store_b at 2; start rises at 3. If alu_done is seen at cycle 3+k, resp_valid rises at cycle 4+k.
- Throughput: at most one operation in flight. The earliest next accept is the cycle after the response handshake.
- alu_done outside EXEC is ignored.
- Back-to-back operations always reload both A and B; datapath operand state is never reused.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ADD/SUB/PAR/COMP;
  - state encoding IDLE, LOAD_A, LOAD_B, EXEC, RESP;
  - the ON/OFF constants.
- No sub-module is needed; the timeout counter stays inline.
- The top-level integration instantiates alu_sequencer alongside alu_datapath.

Test Plan:
1. ADD, A=8'h7F, B=8'h01, datapath model returns done after 2 cycles -> store_a at cycle 1, store_b at cycle 2, start at cycle 3; resp_result=8'h80, resp_overflow=model value, resp_timeout=0, resp_valid at cycle 6.
2. SUB, A=8'h05, B=8'h09 -> resp_result=8'hFC, resp_overflow=1 (borrow). Then PAR/COMP with model overflow=1 -> resp_overflow=0.
3. Datapath model never asserts alu_done, TIMEOUT_CYCLES=16 -> start high for exactly 16 cycles; resp_timeout=1, resp_result=8'h00.
4. Response backpressure: resp_ready=0 for 5 cycles -> resp_valid and fields stay stable, req_ready=0, and a new req_valid is not accepted until one cycle after the handshake.
5. reset_n pulsed low during EXEC -> all outputs 0 immediately (asynchronous); no response; next request runs normally.
6. Spurious alu_done in IDLE/LOAD_A, and alu_done coinciding with the final timeout cycle -> the first is ignored; the second completes normally with resp_timeout=0.
